gen_collector: RTL and testbench
================================

Name: gen_collector

Overview:
- Caller-side initiator for the generator ready/valid protocol emitted for Python generator functions.
- Loads arguments into a generator instance and pulses its start. Drives its ready with FIFO-based backpressure.
- Captures every yielded 2-tuple into an internal FIFO and reports item count and completion.
- Sits between a host/testbench command interface and any 2-output generator module with three 32-bit arguments.

Parameters:
- WIDTH, 32, bit width of each argument and each yielded output.
- DEPTH, 4, capture FIFO entries; must be a power of two, >= 2.
- CNT_W, 16, width of the yielded-item counter.

Ports:
- _clock  in  1  system clock; all logic on the rising edge.
- _reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  one-cycle request to launch a generator run.
- cmd_base, cmd_limit, cmd_step  in  WIDTH each  arguments, sampled when cmd_start is accepted.
- busy  out  1  high from cmd acceptance until run_done.
- run_done  out  1  one-cycle pulse when the generator reports done and the last item is captured.
- item_count  out  CNT_W  items captured in the current or last run; saturates at all-ones.
- gen_base, gen_limit, gen_step  out  WIDTH each  registered arguments to the generator.
- gen_start  out  1  one-cycle start pulse to the generator.
- gen_ready  out  1  consumer ready to the generator.
- gen_valid  in  1  generator output valid.
- gen_done  in  1  generator finished.
- gen_0, gen_1  in  WIDTH each  yielded tuple.
- rd_en  in  1  pop the FIFO head; ignored when empty.
- rd_valid  out  1  FIFO non-empty.
- rd_0, rd_1  out  WIDTH each  FIFO head, valid while rd_valid.

Behaviour:
- Reset (async, active-high) values:
  - Outputs: busy=0, run_done=0, item_count=0, gen_start=0, gen_ready=0, rd_valid=0, gen_* args=0, rd_0/rd_1=0.
  - Internal: FIFO pointers cleared, FSM=IDLE.
- Reset mid-run discards FIFO contents and the run. Reset of the generator itself is the system reset, wired externally.
- FSM states:
  - IDLE: cmd_start=1 latches args into gen_*, item_count<=0, busy<=1, go to LAUNCH. cmd_start is ignored in every other state.
  - LAUNCH: exactly one cycle with gen_start=1 and gen_ready=0, then RUN. The generator may present valid/done in the same cycle as the start pulse; a valid present while gen_ready=0 is not a transfer and is captured in RUN.
  - RUN: gen_ready = (FIFO not full) OR (rd_en AND rd_valid), computed combinationally.
    - Transfer occurs on an edge where gen_valid AND gen_ready: push {gen_0, gen_1}, item_count++ (saturating).
    - gen_done=1 with gen_valid=0 -> go to FINISH.
    - gen_done=1 with gen_valid=1 -> capture first if gen_ready, then FINISH. If not ready, stay until the capture occurs.
  - FINISH: gen_ready<=0, run_done pulses for one cycle, busy<=0, go to IDLE.
- FIFO: first-word-fall-through, DEPTH entries. Simultaneous push and pop when full is allowed (net occupancy unchanged). Pop when empty has no effect. FIFO contents persist across runs until read.
- Ordering guarantee: items are read out in yield order; none dropped, none duplicated.
- Latency: cmd_start to gen_start is 1 cycle. A transfer appears on rd_valid one cycle after the capturing edge.

Decomposition:
- Shared package gen_proto_pkg: FSM state enum (IDLE, LAUNCH, RUN, FINISH) and a tuple typedef {WIDTH out0, WIDTH out1}.
- Sub-module sync_fifo_fwft (WIDTH*2 data, DEPTH) for the capture buffer; reusable by other caller-side blocks.

Test Plan:
1. cmd (0,10,2) with hrange attached, rd_en held 1 -> rd pairs (0,0),(2,2),(4,4),(6,6),(8,8); item_count=5; one run_done pulse.
2. cmd (1,11,3), rd_en=0, DEPTH=4 -> four items captured, gen_ready=0 while full. Then rd_en=1 -> (1,1),(4,4),(7,7),(10,10) in order, no loss, run_done after the last capture.
3. cmd (5,5,1) (empty range) -> gen_done without valid; item_count=0; rd_valid stays 0; run_done 2-4 cycles after cmd_start.
4. cmd_start pulsed again during RUN of (0,10,2) -> ignored; gen_start pulses exactly once; results identical to test 1.
5. Assert _reset asynchronously mid-edge after 2 items of (0,10,2) -> busy, rd_valid, item_count drop to 0 immediately without a clock edge. A new cmd (0,4,1) afterwards yields 0,1,2,3.
6. Random rd_en (50%) over cmd (0,100,7) -> 15 items, scoreboard matches the Python reference list exactly.

Source files
------------

// File: rtl/gen_proto_pkg.sv
// gen_proto_pkg: shared types for caller-side blocks of the generator ready/valid protocol
package gen_proto_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
  } tuple_t;
endpackage

// File: rtl/gen_collector_if.sv
// gen_collector_if: command, generator and readout signals of the collector
interface gen_collector_if #(parameter int WIDTH = gen_proto_pkg::WIDTH, parameter int CNT_W = 16) ();
  logic cmd_start;
  logic [WIDTH-1:0] cmd_base, cmd_limit, cmd_step;
  logic busy, run_done;
  logic [CNT_W-1:0] item_count;
  logic [WIDTH-1:0] gen_base, gen_limit, gen_step;
  logic gen_start, gen_ready, gen_valid, gen_done;
  logic [WIDTH-1:0] gen_0, gen_1;
  logic rd_en, rd_valid;
  logic [WIDTH-1:0] rd_0, rd_1;
  modport master (
    input  cmd_start, cmd_base, cmd_limit, cmd_step, gen_valid, gen_done, gen_0, gen_1, rd_en,
    output busy, run_done, item_count, gen_base, gen_limit, gen_step, gen_start, gen_ready,
           rd_valid, rd_0, rd_1
  );
  modport slave (
    output cmd_start, cmd_base, cmd_limit, cmd_step, gen_valid, gen_done, gen_0, gen_1, rd_en,
    input  busy, run_done, item_count, gen_base, gen_limit, gen_step, gen_start, gen_ready,
           rd_valid, rd_0, rd_1
  );
endinterface

// File: rtl/gen_collector_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO; push while full is accepted only alongside a pop
module sync_fifo_fwft #(parameter int W = 64, parameter int DEPTH = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem_q[rp_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din;
endmodule

// File: rtl/gen_collector.sv
// gen_collector: launches a generator run and captures its yielded tuples into a FWFT FIFO
module gen_collector import gen_proto_pkg::*; #(parameter int DEPTH = 4, parameter int CNT_W = 16) (
  input logic _clock,
  input logic _reset,
  gen_collector_if.master bus
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] base_q, base_d, lim_q, lim_d, step_q, step_d;
  logic accept, ready, push, full, empty;
  tuple_t head;
  assign accept = state_q == IDLE && bus.cmd_start;
  // popping frees a slot in the same edge, so a full FIFO can still accept
  assign ready = state_q == RUN && (!full || (bus.rd_en && !empty));
  assign push = ready && bus.gen_valid;
  sync_fifo_fwft #(.W($bits(tuple_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(_clock), .rst(_reset), .push(push), .pop(bus.rd_en),
    .din(tuple_t'{out0: bus.gen_0, out1: bus.gen_1}), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge _clock or posedge _reset)
    if (_reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.cmd_start ? LAUNCH : IDLE;
      LAUNCH:  state_d = RUN;
      RUN:     state_d = bus.gen_done && (!bus.gen_valid || ready) ? FINISH : RUN;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    base_d = accept ? bus.cmd_base : base_q;
    lim_d = accept ? bus.cmd_limit : lim_q;
    step_d = accept ? bus.cmd_step : step_q;
    cnt_d = accept ? '0 : (push && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge _clock or posedge _reset)
    if (_reset) begin
      base_q <= '0;
      lim_q <= '0;
      step_q <= '0;
      cnt_q <= '0;
    end else begin
      base_q <= base_d;
      lim_q <= lim_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    bus.busy = state_q != IDLE;
    bus.run_done = state_q == FINISH;
    bus.gen_start = state_q == LAUNCH;
    bus.gen_ready = ready;
    bus.item_count = cnt_q;
    bus.gen_base = base_q;
    bus.gen_limit = lim_q;
    bus.gen_step = step_q;
    bus.rd_valid = !empty;
    bus.rd_0 = head.out0;
    bus.rd_1 = head.out1;
  end
endmodule

// File: tb/tb_gen_collector.sv
// tb_gen_collector: drives hrange-style generator runs and scoreboards the readout against a range list
module tb_gen_collector;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  gen_collector_if #(.WIDTH(32), .CNT_W(16)) bus ();
  gen_collector #(.DEPTH(4), .CNT_W(16)) dut (._clock(clk), ._reset(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  // hrange(base, limit, step) yields (v, v); holds each item until it is taken
  logic g_act;
  logic [31:0] g_cur, g_lim, g_stp;
  assign bus.gen_valid = g_act && g_cur < g_lim;
  assign bus.gen_done = g_act && g_cur >= g_lim;
  assign bus.gen_0 = g_cur;
  assign bus.gen_1 = g_cur;
  always @(posedge clk or posedge rst)
    if (rst) begin
      g_act <= 0; g_cur <= 0; g_lim <= 0; g_stp <= 0;
    end else if (bus.gen_start) begin
      g_act <= 1; g_cur <= bus.gen_base; g_lim <= bus.gen_limit; g_stp <= bus.gen_step;
    end else if (bus.gen_valid && bus.gen_ready) g_cur <= g_cur + g_stp;
  // mode 0: always read, 1: hold reads until cycle 12, 2: random reads, 3: stray cmd_start mid-run
  task automatic run(input int b, input int l, input int s, input int mode);
    int q[$];
    int n, st, dn, lat, cyc, e;
    for (int v = b; v < l; v += s) q.push_back(v);
    n = q.size();
    st = 0; dn = 0; lat = -1;
    @(negedge clk);
    bus.cmd_base = b; bus.cmd_limit = l; bus.cmd_step = s;
    bus.cmd_start = 1; bus.rd_en = 0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      bus.cmd_start = mode == 3 && cyc == 3;
      if (cyc == 0) check("busy_run", bus.busy, 1);
      if (bus.gen_start) st++;
      if (bus.run_done) begin
        dn++;
        if (lat < 0) lat = cyc + 1;
      end
      if (mode == 1 && cyc == 12) begin
        check("full_ready", bus.gen_ready, 0);
        check("full_count", bus.item_count, 4);
      end
      bus.rd_en = mode == 1 ? cyc >= 12 : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.rd_en && bus.rd_valid) begin
        if (q.size() == 0) check("extra_item", {bus.rd_0, bus.rd_1}, 0);
        else begin
          e = q.pop_front();
          check("rd_pair", {bus.rd_0, bus.rd_1}, {e[31:0], e[31:0]});
        end
      end
      if (dn > 0 && q.size() == 0 && !bus.rd_valid) break;
    end
    check("timeout", cyc < 2000, 1);
    bus.rd_en = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.run_done) dn++;
      if (bus.gen_start) st++;
    end
    check("run_done_pulses", dn, 1);
    check("gen_start_pulses", st, 1);
    check("item_count", bus.item_count, n);
    check("busy_idle", bus.busy, 0);
    check("rd_valid_idle", bus.rd_valid, 0);
    check("items_left", q.size(), 0);
    if (n == 0) check("done_latency", lat >= 2 && lat <= 4, 1);
  endtask
  initial begin
    bus.cmd_start = 0; bus.cmd_base = 0; bus.cmd_limit = 0; bus.cmd_step = 0; bus.rd_en = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_run_done", bus.run_done, 0);
    check("rst_item_count", bus.item_count, 0);
    check("rst_gen_start", bus.gen_start, 0);
    check("rst_gen_ready", bus.gen_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_args", {bus.gen_base, bus.gen_limit}, 0);
    check("rst_rd", {bus.rd_0, bus.rd_1}, 0);
    rst = 0;
    run(0, 10, 2, 0);
    run(1, 11, 3, 1);
    run(5, 5, 1, 0);
    run(0, 10, 2, 3);
    @(negedge clk);
    bus.cmd_base = 0; bus.cmd_limit = 10; bus.cmd_step = 2; bus.cmd_start = 1; bus.rd_en = 0;
    @(negedge clk);
    bus.cmd_start = 0;
    for (int i = 0; i < 50 && bus.item_count != 2; i++) @(negedge clk);
    check("pre_reset_count", bus.item_count, 2);
    check("pre_reset_rd_valid", bus.rd_valid, 1);
    #2 rst = 1;
    #1;
    check("async_busy", bus.busy, 0);
    check("async_rd_valid", bus.rd_valid, 0);
    check("async_item_count", bus.item_count, 0);
    @(negedge clk);
    rst = 0;
    run(0, 4, 1, 0);
    run(0, 100, 7, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
